// File: rtl/mcu_pkg.sv
// Shared definitions for the conv memory-control path:
// phase codes, host opcodes and small elaboration helpers.
package mcu_pkg;

  localparam logic [1:0] LOAD = 2'b00;
  localparam logic [1:0] PROC = 2'b01;
  localparam logic [1:0] OUT  = 2'b10;

  localparam logic [1:0] CMD_LOAD = 2'b00;
  localparam logic [1:0] CMD_PROC = 2'b01;
  localparam logic [1:0] CMD_OUT  = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic logic [1:0] next_phase(input logic [1:0] p);
    logic [1:0] n;
    n = LOAD;
    unique case (p)
      LOAD:    n = PROC;
      PROC:    n = OUT;
      default: n = LOAD;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mcu_seq_gen_if.sv
// Host command handshake bundle for the
// convolution sequencer.
interface mcu_seq_gen_if #(
  parameter int NB_ADDR = 10
);
  logic               i_cmd_valid;
  logic [1:0]         i_cmd;
  logic [NB_ADDR-1:0] i_cmd_arg;
  logic               o_cmd_ready;

  modport master (
    output i_cmd_valid,
    output i_cmd,
    output i_cmd_arg,
    input  o_cmd_ready
  );

  modport slave (
    input  i_cmd_valid,
    input  i_cmd,
    input  i_cmd_arg,
    output o_cmd_ready
  );
endinterface

// File: rtl/mcu_seq_gen_col_addr_cnt.sv
// Intra-column address counter with IMG_H wrap
// plus completed-column count.
module col_addr_cnt #(
  parameter int IMG_H   = 480,
  parameter int NB_ADDR = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear_i,
  input  logic               step_i,
  input  logic [NB_ADDR-1:0] arg_i,
  output logic [NB_ADDR-1:0] addr_o,
  output logic               eoc_o,
  output logic               last_col_o
);

  logic [NB_ADDR-1:0] addr_q, addr_d;
  logic [NB_ADDR-1:0] col_q, col_d;
  logic [NB_ADDR:0]   col_nx;

  assign eoc_o  = (addr_q == NB_ADDR'(IMG_H - 1));
  assign col_nx = {1'b0, col_q} + (NB_ADDR+1)'(1);
  // The column now finishing is the last one requested
  assign last_col_o = (col_nx >= {1'b0, arg_i});
  assign addr_o = addr_q;

  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    if (clear_i) begin
      addr_d = '0;
      col_d  = '0;
    end else if (step_i) begin
      if (eoc_o) begin
        addr_d = '0;
        col_d  = col_q + 1'b1;
      end else begin
        addr_d = addr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      col_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
    end
  end

endmodule

// File: rtl/mcu_seq_gen.sv
// Host sequencer enforcing LOAD->PROC->OUT order and
// driving phase, column-change and address lines.
module mcu_seq_gen
  import mcu_pkg::*;
#(
  parameter int N       = 2,
  parameter int IMG_H   = 480,
  parameter int NB_ADDR = 10
) (
  input  logic               clk,
  input  logic               rst,
  mcu_seq_gen_if.slave       cmd_if,
  input  logic               i_data_valid,
  input  logic               i_out_ready,
  output logic               o_sop,
  output logic               o_eop,
  output logic               o_chblk,
  output logic [NB_ADDR-1:0] o_addr,
  output logic               o_beat,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (IMG_H < 2 || clog2(IMG_H) > NB_ADDR || N < 1) begin : g_bad_cfg
    $error("mcu_seq_gen: illegal IMG_H/NB_ADDR/N");
  end

  logic [0:0]         state_q, state_d;
  logic [1:0]         phase_q, phase_d;
  logic [1:0]         expect_q, expect_d;
  logic [NB_ADDR-1:0] arg_q, arg_d;
  logic               chblk_q, chblk_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic busy, hs, legal, accept;
  logic beat, eoc, last_col, col_end, last;

  assign busy = (state_q == S_RUN);
  assign cmd_if.o_cmd_ready = !busy;

  assign hs    = cmd_if.i_cmd_valid && !busy;
  assign legal = (cmd_if.i_cmd == expect_q) &&
                 (cmd_if.i_cmd == CMD_PROC ||
                  cmd_if.i_cmd_arg != '0);
  assign accept = hs && legal;

  always_comb begin
    beat = 1'b0;
    if (busy) begin
      unique case (phase_q)
        LOAD:    beat = i_data_valid;
        PROC:    beat = 1'b1;
        OUT:     beat = i_out_ready;
        default: beat = 1'b0;
      endcase
    end
  end

  col_addr_cnt #(
    .IMG_H   (IMG_H),
    .NB_ADDR (NB_ADDR)
  ) u_cnt (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (accept),
    .step_i     (beat),
    .arg_i      (arg_q),
    .addr_o     (o_addr),
    .eoc_o      (eoc),
    .last_col_o (last_col)
  );

  assign col_end = beat && eoc;
  assign last    = col_end &&
                   (phase_q == PROC || last_col);

  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    expect_d = expect_q;
    arg_d    = arg_q;
    err_d    = err_q;
    // Final column gets no strobe: downstream steps on phase entry
    chblk_d  = col_end && !last;
    done_d   = last;
    if (accept) begin
      state_d  = S_RUN;
      phase_d  = cmd_if.i_cmd;
      expect_d = next_phase(cmd_if.i_cmd);
      arg_d    = cmd_if.i_cmd_arg;
    end else if (hs) begin
      err_d = 1'b1;
    end
    if (last) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      phase_q  <= LOAD;
      expect_q <= LOAD;
      arg_q    <= '0;
      chblk_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      expect_q <= expect_d;
      arg_q    <= arg_d;
      chblk_q  <= chblk_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign o_sop   = phase_q[0];
  assign o_eop   = phase_q[1];
  assign o_chblk = chblk_q;
  assign o_beat  = beat;
  assign o_busy  = busy;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_mcu_seq_gen.sv
// Vector-table bench for mcu_seq_gen with IMG_H=4:
// rows hold one cycle of inputs and the post-edge outputs.
module tb_mcu_seq_gen;

  localparam int IMG_H   = 4;
  localparam int NB_ADDR = 10;

  typedef struct {
    logic       rst;
    logic       cv;
    logic [1:0] cmd;
    logic [9:0] arg;
    logic       dv;
    logic       ordy;
    logic       bt;
    logic [1:0] ph;
    logic       chb;
    logic [9:0] addr;
    logic       busy;
    logic       done;
    logic       err;
  } vec_t;

  logic clk;
  logic rst;
  logic i_data_valid;
  logic i_out_ready;
  logic o_sop, o_eop, o_chblk, o_beat;
  logic o_busy, o_done, o_err;
  logic [NB_ADDR-1:0] o_addr;

  mcu_seq_gen_if #(.NB_ADDR(NB_ADDR)) cif ();

  mcu_seq_gen #(
    .N       (2),
    .IMG_H   (IMG_H),
    .NB_ADDR (NB_ADDR)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_if       (cif),
    .i_data_valid (i_data_valid),
    .i_out_ready  (i_out_ready),
    .o_sop        (o_sop),
    .o_eop        (o_eop),
    .o_chblk      (o_chblk),
    .o_addr       (o_addr),
    .o_beat       (o_beat),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  vec_t tbl[$];
  vec_t sb[$];
  int   errors = 0;
  int   checks = 0;

  function automatic void add(
    input logic r, input logic cv,
    input logic [1:0] c, input logic [9:0] a,
    input logic dv, input logic orr, input logic bt,
    input logic [1:0] ph, input logic chb,
    input logic [9:0] ad, input logic bs,
    input logic dn, input logic er);
    vec_t v;
    v.rst = r;  v.cv = cv; v.cmd = c; v.arg = a;
    v.dv = dv;  v.ordy = orr; v.bt = bt;
    v.ph = ph;  v.chb = chb; v.addr = ad;
    v.busy = bs; v.done = dn; v.err = er;
    tbl.push_back(v);
  endfunction

  task automatic chk(input int row, input string nm,
                     input logic [9:0] got,
                     input logic [9:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL row %0d %s: got %0d want %0d",
               row, nm, got, want);
    end
  endtask

  task automatic compare(input int row, input vec_t e);
    chk(row, "phase", 10'({o_eop, o_sop}), 10'(e.ph));
    chk(row, "chblk", 10'(o_chblk), 10'(e.chb));
    chk(row, "addr", o_addr, e.addr);
    chk(row, "busy", 10'(o_busy), 10'(e.busy));
    chk(row, "ready", 10'(cif.o_cmd_ready), 10'(!e.busy));
    chk(row, "done", 10'(o_done), 10'(e.done));
    chk(row, "err", 10'(o_err), 10'(e.err));
  endtask

  initial begin
    int b;
    logic r;
    vec_t e;

    rst = 1'b0;
    i_data_valid = 1'b0;
    i_out_ready = 1'b0;
    cif.i_cmd_valid = 1'b0;
    cif.i_cmd = 2'b00;
    cif.i_cmd_arg = '0;

    // reset, 2 cycles
    add(1,0,0,0,0,0,1'bx, 0,0,0,0,0,0);
    add(1,0,0,0,0,0,0,    0,0,0,0,0,0);
    // LOAD arg=3 then 12 back-to-back beats
    add(0,1,0,3,0,0,0, 0,0,0,1,0,0);
    for (int k = 1; k <= 12; k++)
      add(0,0,0,0,1,0,1, 0, (k==4 || k==8), 10'(k%4),
          (k<12), (k==12), 0);
    add(0,0,0,0,1,0,0, 0,0,0,0,0,0);
    // PROC; last beat coincides with an OUT request (not taken)
    add(0,1,1,0,0,0,0, 1,0,0,1,0,0);
    for (int k = 1; k <= 4; k++)
      add(0,(k==4),2,2,0,0,1, 1,0,10'(k%4),(k<4),(k==4),0);
    add(0,0,0,0,0,0,0, 1,0,0,0,0,0);
    // OUT arg=2 with ready toggling 1,0
    add(0,1,2,2,0,0,0, 2,0,0,1,0,0);
    b = 0;
    for (int i = 0; i < 16; i++) begin
      r = (i % 2 == 0);
      if (r) b++;
      add(0,0,0,0,0,r,r, 2,(r && b==4),10'(b%4),
          (b<8),(r && b==8),0);
    end
    // order violations
    add(1,0,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,1,0,0,0,0, 0,0,0,0,0,1);
    add(1,0,0,0,0,0,0, 0,0,0,0,0,0);
    add(0,1,0,0,0,0,0, 0,0,0,0,0,1);
    add(0,1,3,5,0,0,0, 0,0,0,0,0,1);
    add(1,0,0,0,0,0,0, 0,0,0,0,0,0);
    // reset mid-LOAD after 5 beats
    add(0,1,0,3,0,0,0, 0,0,0,1,0,0);
    for (int k = 1; k <= 5; k++)
      add(0,0,0,0,1,0,1, 0,(k==4),10'(k%4),1,0,0);
    add(1,0,0,0,1,0,1, 0,0,0,0,0,0);
    // single-column LOAD: no chblk on final column
    add(0,1,0,1,0,0,0, 0,0,0,1,0,0);
    for (int k = 1; k <= 4; k++)
      add(0,0,0,0,1,0,1, 0,0,10'(k%4),(k<4),(k==4),0);
    add(0,0,0,0,0,0,0, 0,0,0,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        compare(i - 1, e);
      end
      rst = tbl[i].rst;
      cif.i_cmd_valid = tbl[i].cv;
      cif.i_cmd = tbl[i].cmd;
      cif.i_cmd_arg = tbl[i].arg;
      i_data_valid = tbl[i].dv;
      i_out_ready = tbl[i].ordy;
      #1;
      if (tbl[i].bt !== 1'bx)
        chk(i, "beat", 10'(o_beat), 10'(tbl[i].bt));
      sb.push_back(tbl[i]);
    end
    @(negedge clk);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      compare(tbl.size() - 1, e);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
